// File: rtl/host_xfer_initiator_if.sv
// Command and page-stream handshakes between host-side logic and host_xfer_initiator.
// slave = the initiator block itself; master = the host-side command/stream logic.
interface host_xfer_if #(
  parameter int HDATA_WIDTH = 32
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_write;
  logic                   cmd_done;
  logic                   cmd_error;
  logic                   busy;
  logic [HDATA_WIDTH-1:0] wr_data;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [HDATA_WIDTH-1:0] rd_data;
  logic                   rd_valid;
  logic                   rd_ready;

  modport master (
    output cmd_valid, cmd_write, wr_data, wr_valid, rd_ready,
    input  cmd_ready, cmd_done, cmd_error, busy, wr_ready, rd_data, rd_valid
  );

  modport slave (
    input  cmd_valid, cmd_write, wr_data, wr_valid, rd_ready,
    output cmd_ready, cmd_done, cmd_error, busy, wr_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/host_xfer_initiator.sv
// Page-level transfer master: polls buffer status, then streams one page over hostdata.
// Reads use an in-flight tag pipe plus a RD_LATENCY+1 skid FIFO so rd_ready stalls never drop data.
module host_xfer_initiator #(
  parameter int HDATA_WIDTH    = 32,
  parameter int PAGE_WORDS     = 1024,
  parameter int MAX_BUFQ_DEPTH = 4,
  parameter int RD_LATENCY     = 1,
  parameter int POLL_GAP       = 8,
  parameter int POLL_LIMIT     = 256
) (
  input  logic                   clock_host,
  input  logic                   reset,
  host_xfer_if.slave             xif,
  output logic                   host_select,
  output logic                   hwrite_enable,
  inout  wire  [HDATA_WIDTH-1:0] hostdata_inout,
  output logic                   gs_select,
  output logic                   gs_write_enable,
  input  logic [7:0]             gs_out,
  input  logic                   gs_out_enable
);

  localparam int FIFO_DEPTH = RD_LATENCY + 1;
  localparam int PW         = $clog2(FIFO_DEPTH);
  localparam int CW         = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE, STAT_REQ, STAT_WAIT, POLL_GAP_S, WR_BURST, RD_BURST, RD_DRAIN, FINISH
  } state_t;

  state_t                 state_q, state_d;
  logic                   cmd_write_q, cmd_write_d;
  logic                   err_q, err_d;
  logic [8:0]             poll_cnt_q, poll_cnt_d;
  logic [3:0]             gap_cnt_q, gap_cnt_d;
  logic [10:0]            word_cnt_q, word_cnt_d;
  logic [HDATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [RD_LATENCY-1:0]  tag_q, tag_d;
  logic [HDATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          fifo_cnt_q;

  logic [CW-1:0]          inflight;
  logic [CW:0]            room;
  logic                   issue_wr, issue_rd, capture, pop, bus_oe, stat_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign capture     = tag_q[RD_LATENCY-1];
  assign xif.rd_valid = (fifo_cnt_q != '0);
  assign xif.rd_data  = fifo_q[rd_ptr_q];
  assign pop         = xif.rd_valid && xif.rd_ready;
  assign xif.busy    = (state_q != IDLE) && (state_q != FINISH);

  // Paused write cycles keep the last word on the bus rather than floating it.
  assign hostdata_inout = bus_oe ? (xif.wr_valid ? xif.wr_data : wdat_q) : {HDATA_WIDTH{1'bz}};

  assign stat_ok = gs_out_enable &&
                   (cmd_write_q ? (gs_out != 8'd0) : (gs_out < 8'(MAX_BUFQ_DEPTH - 1)));

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(tag_q[i]);
    // A slot freed by this cycle's pop is already usable by this cycle's issue.
    room = (CW+1)'(FIFO_DEPTH) - {1'b0, fifo_cnt_q} + {{CW{1'b0}}, pop};
  end

  always_comb begin
    state_d         = state_q;
    cmd_write_d     = cmd_write_q;
    err_d           = err_q;
    poll_cnt_d      = poll_cnt_q;
    gap_cnt_d       = gap_cnt_q;
    word_cnt_d      = word_cnt_q;
    wdat_d          = wdat_q;
    xif.cmd_ready   = 1'b0;
    xif.cmd_done    = 1'b0;
    xif.cmd_error   = 1'b0;
    xif.wr_ready    = 1'b0;
    gs_select       = 1'b0;
    gs_write_enable = 1'b0;
    bus_oe          = 1'b0;
    issue_wr        = 1'b0;
    issue_rd        = 1'b0;

    case (state_q)
      IDLE: begin
        xif.cmd_ready = 1'b1;
        if (xif.cmd_valid) begin
          cmd_write_d = xif.cmd_write;
          poll_cnt_d  = '0;
          word_cnt_d  = '0;
          err_d       = 1'b0;
          state_d     = STAT_REQ;
        end
      end
      STAT_REQ: begin
        gs_select       = 1'b1;
        gs_write_enable = cmd_write_q;
        state_d         = STAT_WAIT;
      end
      STAT_WAIT: begin
        if (stat_ok) begin
          state_d = cmd_write_q ? WR_BURST : RD_BURST;
        end else begin
          poll_cnt_d = poll_cnt_q + 9'd1;
          gap_cnt_d  = '0;
          if (poll_cnt_d == 9'(POLL_LIMIT)) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end else begin
            state_d = POLL_GAP_S;
          end
        end
      end
      POLL_GAP_S: begin
        if (gap_cnt_q == 4'(POLL_GAP - 1)) state_d = STAT_REQ;
        else                               gap_cnt_d = gap_cnt_q + 4'd1;
      end
      WR_BURST: begin
        bus_oe = 1'b1;
        if (xif.wr_valid) begin
          issue_wr     = 1'b1;
          xif.wr_ready = 1'b1;
          wdat_d       = xif.wr_data;
          word_cnt_d   = word_cnt_q + 11'd1;
          if (word_cnt_q == 11'(PAGE_WORDS - 1)) state_d = FINISH;
        end
      end
      RD_BURST: begin
        if (room > {1'b0, inflight}) begin
          issue_rd   = 1'b1;
          word_cnt_d = word_cnt_q + 11'd1;
          if (word_cnt_q == 11'(PAGE_WORDS - 1)) state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (inflight == '0 && fifo_cnt_q == '0) state_d = FINISH;
      end
      FINISH: begin
        xif.cmd_done  = !err_q;
        xif.cmd_error = err_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    host_select   = issue_wr || issue_rd;
    hwrite_enable = issue_wr;
  end

  always_comb begin
    tag_d    = '0;
    tag_d[0] = issue_rd;
    for (int i = 1; i < RD_LATENCY; i++) tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clock_host) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_write_q <= 1'b0;
      err_q       <= 1'b0;
      poll_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      word_cnt_q  <= '0;
      wdat_q      <= '0;
      tag_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cmd_write_q <= cmd_write_d;
      err_q       <= err_d;
      poll_cnt_q  <= poll_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      word_cnt_q  <= word_cnt_d;
      wdat_q      <= wdat_d;
      tag_q       <= tag_d;
      if (capture) begin
        fifo_q[wr_ptr_q] <= hostdata_inout;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({capture, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

endmodule

// File: doc/host_xfer_initiator.md
# host_xfer_initiator

Host-domain master for the transfer-buffer host port. It takes page-level commands (write one 4 KB page / read one 4 KB page) and polls buffer status over the gs_* status port until a slot or page is available. It then streams 1024 32-bit words across the shared hostdata bus and reports completion or timeout. It sits between the host-side command/stream logic and the transfer buffer, clocked by clock_host.

## Interface
- HDATA_WIDTH, 32, host data word width
- PAGE_WORDS, 1024, words per page (one buffer slot)
- MAX_BUFQ_DEPTH, 4, buffer ring depth; usable slots = MAX_BUFQ_DEPTH-1
- RD_LATENCY, 1, cycles from a host_select read cycle to its word on hostdata_inout (1..4)
- POLL_GAP, 8, idle cycles between status polls
- POLL_LIMIT, 256, failed polls before a command aborts
- clock_host  in  1  host clock, all logic on rising edge
- reset  in  1  reset, synchronous, active-high; clock clock_host
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_write  in  1  1 = write page to buffer, 0 = read page from buffer
- cmd_done / cmd_error  out  1  one-cycle pulses: page finished / poll timeout
- busy  out  1  high from command accept until the done/error pulse
- wr_data / wr_valid / wr_ready  in/in/out  32/1/1  write-page source stream
- rd_data / rd_valid / rd_ready  out/out/in  32/1/1  read-page sink stream
- host_select / hwrite_enable  out  1  buffer host-port strobe and direction
- hostdata_inout  inout  32  shared data bus; driven only in write cycles, else Z
- gs_select / gs_write_enable  out  1  status request; gs_write_enable=1 selects rx (write) free count, 0 selects tx free count
- gs_out / gs_out_enable  in  8/1  status value and valid

## Operation
- States: IDLE, STAT_REQ, STAT_WAIT, POLL_GAP, WR_BURST, RD_BURST, RD_DRAIN, FINISH.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_write, clear poll_cnt, go to STAT_REQ.
- STAT_REQ: gs_select=1 for one cycle, gs_write_enable=cmd_write. Next state STAT_WAIT.
- STAT_WAIT samples gs_out only if gs_out_enable=1; otherwise the poll counts as failed.
- Write is ready when gs_out != 0 (free slot). Read is ready when gs_out < MAX_BUFQ_DEPTH-1 (at least one page held).
- Ready: go to WR_BURST or RD_BURST. Not ready: poll_cnt+1. If poll_cnt reaches POLL_LIMIT, go to FINISH with error; else go to POLL_GAP for POLL_GAP cycles, then STAT_REQ.
- WR_BURST: a transfer cycle occurs iff wr_valid=1. In it, host_select=1, hwrite_enable=1, hostdata_inout=wr_data, wr_ready=1.
  - wr_valid=0 gives host_select=0 (pause) with the bus still driven with the last word.
  - After word PAGE_WORDS-1, go to FINISH.
- RD_BURST: issue a read cycle (host_select=1, hwrite_enable=0, bus Z) only while skid-FIFO free entries exceed in-flight reads.
  - Skid FIFO depth RD_LATENCY+1. Each issued cycle pushes a tag into an RD_LATENCY-deep shift register; when the tag emerges, hostdata_inout is captured into the FIFO.
  - rd_valid = FIFO non-empty; pop on rd_valid&&rd_ready.
  - After PAGE_WORDS issues, go to RD_DRAIN; leave when in-flight=0 and FIFO empty, then go to FINISH.
- FINISH: one cycle; pulse cmd_done (or cmd_error on timeout), busy falls, then IDLE.
- Counters: word_cnt 11 bits (0..PAGE_WORDS), poll_cnt 9 bits, gap_cnt 4 bits. All widths saturate-free by construction.
- cmd_write is ignored except at accept; cmd_valid while busy is not accepted.

## Timing
- Reset values: cmd_ready=1, cmd_done=0, cmd_error=0, busy=0, wr_ready=0, rd_valid=0, rd_data=0, host_select=0, hwrite_enable=0, gs_select=0, gs_write_enable=0, bus Z. FIFO, counters and tags are cleared.
- Accept in cycle C: gs_select at C+1, sample at C+2, first write/read issue at earliest C+3.
- Back-to-back write: 1024 consecutive host_select cycles; done pulse one cycle after the last word.
- Read with rd_ready=1 always: a word issued at T gives rd_valid at T+RD_LATENCY+1. There are no issue gaps.
- Bus turnaround: hostdata_inout is driven only in WR_BURST and released the cycle FINISH is entered.
- Reset mid-burst returns to IDLE next cycle. It drops host_select and the bus, and gives no done/error pulse. The partial page is abandoned; the buffer is re-reset by the system.

## Test plan
- Write, gs_out=3 at first poll, wr_valid=1 continuously -> host_select high exactly 1024 cycles starting C+3, words 0..1023 on bus in order, cmd_done at C+1027.
- Write with wr_valid low every 4th cycle -> host_select=0 on those cycles, still exactly 1024 strobes, data order intact, no duplicated word.
- Read, RD_LATENCY=2, gs_out=2 (one page held), rd_ready toggling 50% -> 1024 rd_valid&&rd_ready beats equal to model data, FIFO never overflows, cmd_done after last pop.
- Write with gs_out=0 for 5 polls then 1 -> 5 POLL_GAP intervals (8 cycles each), burst starts after 6th poll; read with gs_out=3 always and POLL_LIMIT=4 -> cmd_error pulse, no host_select ever.
- gs_out_enable held low -> every poll fails, cmd_error after POLL_LIMIT polls.
- Reset asserted at word 500 of a write -> next cycle host_select=0, bus Z, cmd_ready=1, no cmd_done; a new command then completes normally.
